// File: rtl/gt1_pkg.sv
// ---------------------------------------------------------------------------
// gt1_pkg
//   Shared definitions for the GT1 program-image loader.
//   - gt1_state_t    : loader FSM state encoding
//   - gt1_addr_t     : 16-bit Gigatron address
//   - GT1_END_MARKER : segment-high byte that terminates the segment list
//   - GT1_PAGE_BYTES : size of one RAM page; segments may not cross one
//   - gt1_seg_len()  : decodes a GT1 length byte (0x00 means a full page)
// ---------------------------------------------------------------------------
package gt1_pkg;

  typedef logic [15:0] gt1_addr_t;

  localparam logic [7:0] GT1_END_MARKER = 8'h00;
  localparam int         GT1_PAGE_BYTES = 256;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SEG_HI  = 4'd1,
    S_SEG_LO  = 4'd2,
    S_SEG_LEN = 4'd3,
    S_DATA    = 4'd4,
    S_EXEC_HI = 4'd5,
    S_EXEC_LO = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } gt1_state_t;

  // A length byte of zero encodes a full page, so the count needs 9 bits.
  function automatic logic [8:0] gt1_seg_len(input logic [7:0] len_byte);
    if (len_byte == 8'h00) begin
      return 9'(GT1_PAGE_BYTES);
    end
    return {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/gt1_loader.sv
// ---------------------------------------------------------------------------
// gt1_loader
//   Streams a GT1 program image out of the option ROM (one byte per cycle),
//   walks its segment list and writes every payload byte into main RAM
//   through a ready-gated write port, then captures the execute address
//   from the trailer for the boot logic.
//
// Parameters
//   ROM_BYTES    : size of the ROM image window; fetching at or past
//                  START_OFFSET + ROM_BYTES aborts the load
//   START_OFFSET : ROM offset of the first GT1 byte
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle pulse, starts a load when idle
//   rom_addr   out  ROM byte address (ROM answers combinationally)
//   rom_data   in   ROM byte at rom_addr
//   ram_addr   out  RAM write address
//   ram_wdata  out  RAM write data
//   ram_we     out  RAM write request, held until accepted
//   ram_ready  in   RAM accepts the write when ram_we && ram_ready
//   busy       out  load in progress
//   done       out  sticky, load completed
//   error      out  sticky, load aborted (page crossing or ROM overrun)
//   exec_addr  out  execute address taken from the trailer
//   exec_valid out  exec_addr is valid (set together with done)
//   checksum   out  only with GT1_LOADER_CHECKSUM_EN defined: mod-256 sum
//                   of all accepted write data, valid when done
//
// Build option
//   GT1_LOADER_CHECKSUM_EN : adds the checksum output and its adder.
// ---------------------------------------------------------------------------
module gt1_loader
  import gt1_pkg::*;
#(
  parameter int ROM_BYTES    = 32768,
  parameter int START_OFFSET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic        ram_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] exec_addr,
  output logic        exec_valid
`ifdef GT1_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  // The fetch pointer carries one extra bit so an image window that ends
  // exactly at 64K can be compared without the pointer wrapping to zero.
  localparam logic [16:0] START_PTR = 17'(START_OFFSET);
  localparam logic [16:0] END_PTR   = 17'(START_OFFSET + ROM_BYTES);

  gt1_state_t  state;
  gt1_state_t  state_next;
  logic [16:0] ptr;
  logic [7:0]  seg_hi;
  logic [7:0]  seg_lo;
  logic [8:0]  seg_len;
  logic [8:0]  index;
  logic [7:0]  seg_count;

  logic        overrun;
  logic [8:0]  len_decoded;
  logic [9:0]  seg_end;
  logic        crosses;
  logic        accept;
  logic        last_byte;
  logic        in_data;

  // Any state that would consume the byte at ptr must first check that
  // ptr is still inside the ROM window.
  assign overrun     = (ptr >= END_PTR);
  assign len_decoded = gt1_seg_len(rom_data);
  assign seg_end     = {2'b00, seg_lo} + {1'b0, len_decoded};
  assign crosses     = (seg_end > 10'(GT1_PAGE_BYTES));
  assign in_data     = (state == S_DATA);
  assign last_byte   = ((index + 9'd1) == seg_len);

  // Only registered state feeds the write address/data, so a stall on
  // ram_ready simply freezes ptr and index and everything holds stable.
  assign ram_we    = in_data && !overrun;
  assign ram_addr  = in_data ? {seg_hi, seg_lo + index[7:0]} : 16'h0000;
  assign ram_wdata = in_data ? rom_data : 8'h00;
  assign accept    = ram_we && ram_ready;

  // The pointer stops at END_PTR at most; the top bit only shows up when
  // the window ends at 64K, in which case the address pins saturate.
  assign rom_addr = ptr[16] ? 16'hFFFF : ptr[15:0];

  // Next-state decode. An overrun in any fetching state diverts to ERROR
  // before the byte is used. A zero high byte only ends the list once at
  // least one segment has been loaded; before that it is page zero.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SEG_HI;
        end
      end
      S_SEG_HI: begin
        if (overrun) begin
          state_next = S_ERROR;
        end else if ((rom_data == GT1_END_MARKER) && (seg_count != 8'd0)) begin
          state_next = S_EXEC_HI;
        end else begin
          state_next = S_SEG_LO;
        end
      end
      S_SEG_LO: begin
        state_next = overrun ? S_ERROR : S_SEG_LEN;
      end
      S_SEG_LEN: begin
        state_next = (overrun || crosses) ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (overrun) begin
          state_next = S_ERROR;
        end else if (accept && last_byte) begin
          state_next = S_SEG_HI;
        end
      end
      S_EXEC_HI: begin
        state_next = overrun ? S_ERROR : S_EXEC_LO;
      end
      S_EXEC_LO: begin
        state_next = overrun ? S_ERROR : S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_ERROR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and status registers. Each fetching state advances ptr only
  // when it actually consumes the byte; status flags are updated on entry
  // to DONE/ERROR so they are visible during that one-cycle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= START_PTR;
      seg_hi     <= 8'h00;
      seg_lo     <= 8'h00;
      seg_len    <= 9'd0;
      index      <= 9'd0;
      seg_count  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      exec_addr  <= 16'h0000;
      exec_valid <= 1'b0;
`ifdef GT1_LOADER_CHECKSUM_EN
      checksum   <= 8'h00;
`endif
    end else begin
      state <= state_next;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            ptr        <= START_PTR;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            exec_valid <= 1'b0;
            seg_count  <= 8'd0;
`ifdef GT1_LOADER_CHECKSUM_EN
            checksum   <= 8'h00;
`endif
          end
        end
        S_SEG_HI: begin
          if (!overrun) begin
            seg_hi <= rom_data;
            ptr    <= ptr + 17'd1;
          end
        end
        S_SEG_LO: begin
          if (!overrun) begin
            seg_lo <= rom_data;
            ptr    <= ptr + 17'd1;
          end
        end
        S_SEG_LEN: begin
          if (state_next == S_DATA) begin
            seg_len <= len_decoded;
            index   <= 9'd0;
            ptr     <= ptr + 17'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            ptr   <= ptr + 17'd1;
            index <= index + 9'd1;
`ifdef GT1_LOADER_CHECKSUM_EN
            checksum <= checksum + rom_data;
`endif
            // Saturating: the count only needs to tell "none" from "some".
            if (last_byte && (seg_count != 8'hFF)) begin
              seg_count <= seg_count + 8'd1;
            end
          end
        end
        S_EXEC_HI: begin
          if (!overrun) begin
            exec_addr[15:8] <= rom_data;
            ptr             <= ptr + 17'd1;
          end
        end
        S_EXEC_LO: begin
          if (!overrun) begin
            exec_addr[7:0] <= rom_data;
            ptr            <= ptr + 17'd1;
          end
        end
        default: begin
        end
      endcase

      if ((state_next == S_DONE) && (state != S_DONE)) begin
        done       <= 1'b1;
        exec_valid <= 1'b1;
        busy       <= 1'b0;
      end

      if ((state_next == S_ERROR) && (state != S_ERROR)) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gt1_loader.md
Name: gt1_loader

Overview:
- Reads a GT1 program image out of the option ROM, one byte per cycle, over its 16-bit address / 8-bit data port.
- Parses the segment structure and writes each payload byte into Gigatron main RAM through a ready-gated write port.
- Captures the execute address so boot logic can redirect the vCPU.
- Sits between the option ROM and the RAM arbiter; the host menu triggers it.

Parameters:
- ROM_BYTES, 32768, size of the ROM image window; any fetch at or beyond this offset is an overrun error.
- START_OFFSET, 0, ROM offset of the first GT1 byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load when idle
- rom_addr  out  16  ROM byte address; ROM is combinational, so rom_data is valid in the same cycle
- rom_data  in  8  ROM byte
- ram_addr  out  16  RAM write address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  write request; held until accepted
- ram_ready  in  1  write accepted when ram_we && ram_ready at a clk edge
- busy  out  1  load in progress
- done  out  1  sticky; load finished OK; cleared by the next accepted start
- error  out  1  sticky; load aborted; cleared by the next accepted start
- exec_addr  out  16  execute address from the GT1 trailer
- exec_valid  out  1  exec_addr captured (set together with done)

Behaviour:
- Reset values: all outputs 0; rom_addr = START_OFFSET; state = IDLE.
- Reset mid-load aborts immediately. No further writes; done, error and exec_valid are cleared.
- FSM states: IDLE, SEG_HI, SEG_LO, SEG_LEN, DATA, EXEC_HI, EXEC_LO, DONE, ERROR.
- IDLE:
  - start -> SEG_HI, with rom_addr = START_OFFSET, busy = 1, and done, error, exec_valid cleared.
  - start is ignored when busy = 1.
- SEG_HI:
  - Latches the address high byte, rom_addr++.
  - If rom_data == 0x00 and at least one segment is complete -> EXEC_HI (end marker).
  - Otherwise -> SEG_LO. A first segment at page 0x00 is legal.
- SEG_LO: latch the low byte, rom_addr++, -> SEG_LEN.
- SEG_LEN:
  - Length byte; 0x00 means 256. Count is held in 9 bits.
  - If lo + len > 256 (segment crosses a page) -> ERROR. Otherwise -> DATA, rom_addr++.
- DATA:
  - ram_we = 1, ram_addr = {hi, lo + index}, ram_wdata = rom_data.
  - On accept: rom_addr++, index++.
  - After the last byte -> SEG_HI, and the completed-segment count increments.
  - While ram_ready = 0, every address and data output holds stable.
  - Sustained throughput is 1 byte/cycle.
- EXEC_HI, EXEC_LO: capture exec_addr[15:8], then exec_addr[7:0], advancing rom_addr each time; then -> DONE.
- DONE: done = 1, exec_valid = 1, busy = 0 (all in the same cycle). DONE -> IDLE on the following cycle; done and exec_valid stay set.
- ERROR: error = 1, busy = 0, ram_we = 0; -> IDLE on the following cycle.
- Overrun:
  - Any state that would consume a byte at rom_addr >= START_OFFSET + ROM_BYTES -> ERROR instead.
  - rom_addr never wraps.
- ram_we is never asserted outside DATA.
- No combinational path from ram_ready to ram_addr or ram_wdata.
- Execute address is fully decoupled: the block does not drive the CPU.

Optional Feature:
- GT1_LOADER_CHECKSUM_EN
  - Defined: adds output checksum[7:0]. It is the mod-256 sum of every accepted RAM write data byte, cleared on the accepted start, and valid when done = 1.
  - Undefined: port and adder absent; no other behavioural difference.

Decomposition:
- Package gt1_pkg:
  - state enum gt1_state_t
  - GT1_END_MARKER = 8'h00
  - GT1_PAGE_BYTES = 256
  - typedef gt1_addr_t (16 bits)
- No sub-module; single FSM with datapath registers.

Test Plan:
- Image 02 00 03 AA BB CC 00 02 00, ram_ready = 1:
  - writes 0x0200=AA, 0x0201=BB, 0x0202=CC on 3 consecutive cycles
  - exec_addr = 0x0200, done = 1, error = 0
- Segment 03 00 00 + 256 bytes (0x00..0xFF) then trailer:
  - 256 writes to 0x0300..0x03FF with data equal to the low address byte, then done.
- Segment 04 F0 20 (crosses page) -> error = 1, zero writes, busy drops.
- ram_ready toggled 0/1 every other cycle on the first image:
  - same 3 writes, each held stable through stalls, done asserted later.
- Reset asserted after the second data write of a 256-byte segment:
  - all outputs 0 next cycle, no further writes.
  - A fresh start reloads from START_OFFSET.
- ROM_BYTES = 8 with a 9-byte image:
  - error at the trailer fetch, exec_valid = 0.
  - A start pulse while busy during the load has no effect.
